xnor_conv_acc_pe: RTL and testbench



---
 rtl/xnor_conv_acc_pe.sv | 96 +++++++++
 tb/tb_xnor_conv_acc_pe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/xnor_conv_acc_pe.sv
// xnor_conv_acc_pe: XNOR-popcount of an activation window against a stored weight,
// accumulated over a programmable beat count and returned through valid/ready.
module xnor_conv_acc_pe #(
    parameter int K_BITS  = 25,
    parameter int ACC_MAX = 16,
    parameter int LEN_W   = 5,
    parameter int OUT_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_load,
    input  logic [K_BITS-1:0] w_data,
    input  logic [LEN_W-1:0]  acc_len,
    input  logic              bipolar,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [K_BITS-1:0] in_a,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              err
);
    localparam int PW = $clog2(K_BITS + 1);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

    state_t            state, state_n;
    logic              live;
    logic [K_BITS-1:0] weight;
    logic [PW-1:0]     pop;
    logic              pop_v;
    logic [OUT_W-1:0]  acc, sum, result;
    logic [LEN_W-1:0]  cnt, len, len_n;
    logic              bip, accept, w_ok, clamp;

    assign in_ready  = live && (state == IDLE || state == ACC);
    assign accept    = in_valid && in_ready;
    assign out_valid = state == HOLD;
    assign w_ok      = state == IDLE && !accept;
    assign clamp     = acc_len > LEN_W'(ACC_MAX);
    assign len_n     = acc_len == '0 ? LEN_W'(1) : clamp ? LEN_W'(ACC_MAX) : acc_len;
    assign sum       = acc + OUT_W'(pop);
    // Intermediate 2*sum may wrap; the final bipolar value always fits OUT_W.
    assign result    = bip ? (sum << 1) - OUT_W'(K_BITS) * OUT_W'(len) : sum;

    always_comb begin
        state_n = state;
        if (state == IDLE && accept)
            state_n = len_n == LEN_W'(1) ? DRAIN : ACC;
        else if (state == ACC && accept && cnt + 1'b1 == len)
            state_n = DRAIN;
        else if (state == DRAIN)
            state_n = HOLD;
        else if (state == HOLD && out_ready)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            live     <= 1'b0;
            weight   <= '0;
            pop      <= '0;
            pop_v    <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            len      <= '0;
            bip      <= 1'b0;
            out_data <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_n;
            live  <= 1'b1;
            pop_v <= accept;
            if (accept)
                pop <= PW'($countones(~(in_a ^ weight)));
            if (w_load && w_ok)
                weight <= w_data;
            if (state == IDLE && accept) begin
                len <= len_n;
                bip <= bipolar;
                cnt <= LEN_W'(1);
                acc <= '0;
            end else begin
                if (accept)
                    cnt <= cnt + 1'b1;
                if (pop_v)
                    acc <= sum;
            end
            if (state == DRAIN)
                out_data <= result;
            if ((w_load && !w_ok) || (state == IDLE && accept && clamp))
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_xnor_conv_acc_pe.sv
// tb_xnor_conv_acc_pe: vector table, directed corner sequences and randomized runs
// checked against a sum-of-matching-bits reference model.
module tb_xnor_conv_acc_pe;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        w_load = 1'b0;
    logic [24:0] w_data = '0;
    logic [4:0]  acc_len = '0;
    logic        bipolar = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] in_a = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_data;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [24:0]      w;
        logic [3:0][24:0] a;
        int               n;
        logic [4:0]       len;
        bit               bip;
        int               gap;
        int               hold;
        logic [9:0]       exp;
    } vec_t;

    vec_t        tbl [8];
    logic [24:0] q [$];

    xnor_conv_acc_pe dut (
        .clk(clk), .reset(reset), .w_load(w_load), .w_data(w_data),
        .acc_len(acc_len), .bipolar(bipolar), .in_valid(in_valid),
        .in_ready(in_ready), .in_a(in_a), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int model(logic [24:0] w, logic [24:0] a [$], bit bip);
        int s = 0;
        foreach (a[i]) s += 25 - $countones(a[i] ^ w);
        return bip ? 2 * s - 25 * a.size() : s;
    endfunction

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(logic [24:0] w);
        w_load = 1'b1;
        w_data = w;
        step();
        w_load = 1'b0;
    endtask

    task automatic beat(string nm, logic [24:0] a);
        check({nm, " in_ready before beat"}, in_ready, 1);
        in_valid = 1'b1;
        in_a = a;
        step();
        in_valid = 1'b0;
    endtask

    task automatic collect(string nm, logic [9:0] exp, int hold);
        check({nm, " out_valid low after last accept"}, out_valid, 0);
        step();
        check({nm, " out_valid"}, out_valid, 1);
        check({nm, " out_data"}, out_data, exp);
        check({nm, " in_ready low in hold"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            step();
            check({nm, " held out_valid"}, out_valid, 1);
            check({nm, " held out_data"}, out_data, exp);
            check({nm, " held in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({nm, " out_valid drop"}, out_valid, 0);
        check({nm, " in_ready back"}, in_ready, 1);
    endtask

    task automatic run(string nm, logic [24:0] a [$], logic [4:0] len, bit bip,
                       int gap, int hold, logic [9:0] exp);
        acc_len = len;
        bipolar = bip;
        foreach (a[i]) begin
            beat(nm, a[i]);
            if (i == 0) begin
                acc_len = 5'($urandom);
                bipolar = ~bip;
            end
            if (i == gap && i < a.size() - 1) step();
        end
        collect(nm, exp, hold);
    endtask

    task automatic do_reset(string nm);
        reset = 1'b0;
        in_valid = 1'b1;
        step();
        step();
        check({nm, " in_ready in reset"}, in_ready, 0);
        check({nm, " out_valid in reset"}, out_valid, 0);
        check({nm, " out_data in reset"}, out_data, 0);
        check({nm, " err in reset"}, err, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        check({nm, " in_ready after release"}, in_ready, 1);
    endtask

    initial begin
        tbl[0] = '{w: 25'h1FFFFFF, a: {25'h0, 25'h0, 25'h0, 25'h0000001}, n: 1, len: 5'd1, bip: 0, gap: -1, hold: 0, exp: 10'd1};
        tbl[1] = '{w: 25'h1FFFFFF, a: {25'h0, 25'h0, 25'h0, 25'h1555555}, n: 1, len: 5'd1, bip: 0, gap: -1, hold: 0, exp: 10'd13};
        tbl[2] = '{w: 25'h0000000, a: {25'h0, 25'h0, 25'h0, 25'h0000000}, n: 1, len: 5'd1, bip: 0, gap: -1, hold: 0, exp: 10'd25};
        tbl[3] = '{w: 25'h1FFFFFF, a: {25'h0000001, 25'h1555555, 25'h0000000, 25'h1FFFFFF}, n: 4, len: 5'd4, bip: 0, gap: 1, hold: 5, exp: 10'd39};
        tbl[4] = '{w: 25'h1FFFFFF, a: {25'h0000001, 25'h1555555, 25'h0000000, 25'h1FFFFFF}, n: 4, len: 5'd4, bip: 1, gap: 1, hold: 0, exp: 10'h3EA};
        tbl[5] = '{w: 25'h0000000, a: {25'h0, 25'h0, 25'h0, 25'h0000000}, n: 1, len: 5'd0, bip: 0, gap: -1, hold: 0, exp: 10'd25};
        tbl[6] = '{w: 25'h0000000, a: {25'h0, 25'h0, 25'h0, 25'h1FFFFFF}, n: 1, len: 5'd1, bip: 1, gap: -1, hold: 0, exp: 10'h3E7};
        tbl[7] = '{w: 25'h1555555, a: {25'h0, 25'h0, 25'h0, 25'h1555555}, n: 1, len: 5'd1, bip: 1, gap: -1, hold: 2, exp: 10'd25};

        do_reset("por");

        foreach (tbl[i]) begin
            load_w(tbl[i].w);
            q.delete();
            for (int j = 0; j < tbl[i].n; j++) q.push_back(tbl[i].a[j]);
            run($sformatf("vec%0d", i), q, tbl[i].len, tbl[i].bip, tbl[i].gap, tbl[i].hold, tbl[i].exp);
        end
        check("err clear after legal traffic", err, 0);

        // Weight load while accumulating is dropped: second beat still sees all-ones weight.
        load_w(25'h1FFFFFF);
        acc_len = 5'd2;
        bipolar = 1'b0;
        beat("wload_acc", 25'h1FFFFFF);
        w_load = 1'b1;
        w_data = 25'h0;
        step();
        w_load = 1'b0;
        check("wload_acc err", err, 1);
        beat("wload_acc", 25'h1FFFFFF);
        collect("wload_acc", 10'd50, 0);

        // Reset after 2 of 4 beats aborts and zeroes the weight.
        do_reset("clr_err");
        load_w(25'h1FFFFFF);
        acc_len = 5'd4;
        beat("abort", 25'h1FFFFFF);
        beat("abort", 25'h1FFFFFF);
        do_reset("abort");
        q.delete();
        q.push_back(25'h1FFFFFF);
        run("post_reset", q, 5'd1, 0, -1, 0, 10'd0);
        check("post_reset err", err, 0);

        // acc_len above ACC_MAX clamps to 16 beats and flags err.
        q.delete();
        for (int j = 0; j < 16; j++) q.push_back(25'h0);
        run("clamp", q, 5'd20, 0, 7, 0, 10'd400);
        check("clamp err", err, 1);

        // Weight load coincident with an accepted IDLE beat is dropped.
        do_reset("coinc");
        acc_len = 5'd1;
        w_load = 1'b1;
        w_data = 25'h1FFFFFF;
        beat("coinc", 25'h0);
        w_load = 1'b0;
        collect("coinc", 10'd25, 0);
        check("coinc err", err, 1);
        q.delete();
        q.push_back(25'h0);
        run("coinc_weight_kept", q, 5'd1, 0, -1, 0, 10'd25);

        do_reset("rand");
        begin
            logic [24:0] cur_w = '0;
            for (int r = 0; r < 40; r++) begin
                int  l   = $urandom_range(0, 16);
                int  nb  = l == 0 ? 1 : l;
                bit  bp  = 1'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    cur_w = 25'($urandom);
                    load_w(cur_w);
                end
                q.delete();
                for (int j = 0; j < nb; j++) q.push_back(25'($urandom));
                run($sformatf("rand%0d", r), q, 5'(l), bp, $urandom_range(0, nb),
                    $urandom_range(0, 2), 10'(model(cur_w, q, bp)));
            end
        end
        check("rand err clear", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
